// File: rtl/risc_prog_sequencer_if.sv
// Host-to-sequencer image stream: one (addr, word, is_data) beat per valid/ready handshake.
//   valid    host -> seq  beat valid
//   ready    seq -> host  beat accepted this cycle when valid is also high
//   is_data  host -> seq  1 = data memory, 0 = instruction memory
//   addr     host -> seq  target address
//   word     host -> seq  word to write
//   last     host -> seq  final beat of the image
interface risc_prog_sequencer_if #(
  parameter int unsigned AW = 16
);
  logic          valid;
  logic          ready;
  logic          is_data;
  logic [AW-1:0] addr;
  logic [15:0]   word;
  logic          last;

  modport master (
    output valid,
    output is_data,
    output addr,
    output word,
    output last,
    input  ready
  );

  modport slave (
    input  valid,
    input  is_data,
    input  addr,
    input  word,
    input  last,
    output ready
  );
endinterface

// File: rtl/risc_prog_sequencer.sv
// Loads a program/data image into the CPU memories over the host stream, then resets and runs
// the CPU until it halts or a cycle budget runs out.
//   clk, clr          clock and synchronous active-high reset
//   start             begins a load from IDLE/DONE/TMO
//   host              image stream (slave side)
//   test_normal       1 = memories owned by the external port
//   ext_instr_*       instruction memory write port
//   ext_data_*        data memory write port
//   cpu_clr/cpu_done  CPU reset and halt flag
//   busy, run_ok, timeout, cycle_cnt  status
module risc_prog_sequencer #(
  parameter int unsigned AW      = 16,
  parameter int unsigned RST_CYC = 2,
  parameter int unsigned CW      = 16,
  parameter int unsigned MAX_CYC = 4096
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 start,
  risc_prog_sequencer_if.slave host,
  output logic                 test_normal,
  output logic                 ext_instr_we,
  output logic [AW-1:0]        ext_instr_addr,
  output logic [15:0]          ext_instr_data,
  output logic                 ext_data_we,
  output logic [AW-1:0]        ext_data_addr,
  output logic [15:0]          ext_data_data,
  output logic                 cpu_clr,
  input  logic                 cpu_done,
  output logic                 busy,
  output logic                 run_ok,
  output logic                 timeout,
  output logic [CW-1:0]        cycle_cnt
);

  localparam int unsigned RCW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
  localparam logic [RCW-1:0] RstLast = RCW'(RST_CYC - 1);
  localparam logic [CW-1:0]  CntLast = CW'(MAX_CYC - 1);

  typedef enum logic [2:0] {StIdle, StLoad, StRst, StRun, StDone, StTmo} state_e;

  state_e         state_q;
  logic [RCW-1:0] rst_cnt_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q        <= StIdle;
      rst_cnt_q      <= '0;
      host.ready     <= 1'b0;
      test_normal    <= 1'b1;
      cpu_clr        <= 1'b1;
      busy           <= 1'b0;
      run_ok         <= 1'b0;
      timeout        <= 1'b0;
      cycle_cnt      <= '0;
      ext_instr_we   <= 1'b0;
      ext_instr_addr <= '0;
      ext_instr_data <= '0;
      ext_data_we    <= 1'b0;
      ext_data_addr  <= '0;
      ext_data_data  <= '0;
    end else begin
      // Write strobes are single-cycle; only an accepted beat re-arms one.
      ext_instr_we <= 1'b0;
      ext_data_we  <= 1'b0;

      case (state_q)
        StIdle, StDone, StTmo: begin
          if (start) begin
            state_q     <= StLoad;
            host.ready  <= 1'b1;
            test_normal <= 1'b1;
            cpu_clr     <= 1'b1;
            busy        <= 1'b1;
            run_ok      <= 1'b0;
            timeout     <= 1'b0;
            cycle_cnt   <= '0;
          end
        end

        StLoad: begin
          // ready is always high here, so valid alone means the beat fires.
          if (host.valid) begin
            if (host.is_data) begin
              ext_data_we   <= 1'b1;
              ext_data_addr <= host.addr;
              ext_data_data <= host.word;
            end else begin
              ext_instr_we   <= 1'b1;
              ext_instr_addr <= host.addr;
              ext_instr_data <= host.word;
            end
            if (host.last) begin
              state_q     <= StRst;
              host.ready  <= 1'b0;
              test_normal <= 1'b0;
              rst_cnt_q   <= '0;
            end
          end
        end

        StRst: begin
          if (rst_cnt_q == RstLast) begin
            state_q <= StRun;
            cpu_clr <= 1'b0;
          end else begin
            rst_cnt_q <= rst_cnt_q + RCW'(1);
          end
        end

        StRun: begin
          // Halt takes priority over the budget limit in the same cycle.
          if (cpu_done) begin
            state_q <= StDone;
            run_ok  <= 1'b1;
            busy    <= 1'b0;
          end else if (cycle_cnt == CntLast) begin
            state_q <= StTmo;
            timeout <= 1'b1;
            cpu_clr <= 1'b1;
            busy    <= 1'b0;
          end else begin
            cycle_cnt <= cycle_cnt + CW'(1);
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
